// File: rtl/imem_loader.sv
// Boot loader: length-prefixed big-endian 16-bit word stream -> instruction memory writes; holds CPU in reset until loaded.
// Latency: imem_we one cycle after the DATA_LO byte handshake; cpu_rst rises one cycle after entering DONE.
// Backpressure: in_ready is registered, high while loading and low in DONE/ERR; nothing advances without in_valid & in_ready.
// Optional checksum trailer byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int IMEM_DEPTH = 512,
    parameter int ADDR_W     = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error
);

    localparam logic [2:0] LEN_HI  = 3'd0;
    localparam logic [2:0] LEN_LO  = 3'd1;
    localparam logic [2:0] DATA_HI = 3'd2;
    localparam logic [2:0] DATA_LO = 3'd3;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] CHK     = 3'd4;
`endif
    localparam logic [2:0] DONE    = 3'd5;
    localparam logic [2:0] ERR     = 3'd6;

    localparam logic [15:0]     DEPTH16 = 16'(IMEM_DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [7:0]        len_hi;
    logic [7:0]        hi_byte;
    // One bit wider than the address so a full-depth image needs no wrap.
    logic [ADDR_W:0]   k;
    logic [ADDR_W:0]   last_k;
    logic              hs;
    logic [15:0]       n_val;
    logic              len_bad;
    logic              last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign hs        = in_valid & in_ready;
    assign n_val     = {len_hi, in_data};
    assign len_bad   = (n_val == 16'd0) || (n_val > DEPTH16);
    assign last_word = (k == last_k);

    // Next-state decode; every transition is gated by a byte handshake.
    always_comb begin
        state_nxt = state;
        if (hs) begin
            case (state)
                LEN_HI:  state_nxt = LEN_LO;
                LEN_LO:  state_nxt = len_bad ? ERR : DATA_HI;
                DATA_HI: state_nxt = DATA_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
                DATA_LO: state_nxt = last_word ? CHK : DATA_HI;
                CHK:     state_nxt = (in_data == csum) ? DONE : ERR;
`else
                DATA_LO: state_nxt = last_word ? DONE : DATA_HI;
`endif
                default: state_nxt = state;
            endcase
        end
    end

    // FSM state, captured length/high byte and word index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= LEN_HI;
            len_hi  <= 8'd0;
            hi_byte <= 8'd0;
            k       <= '0;
            last_k  <= '0;
        end else begin
            state <= state_nxt;
            if (hs && state == LEN_HI) len_hi <= in_data;
            if (hs && state == LEN_LO) begin
                k      <= '0;
                last_k <= (ADDR_W+1)'(n_val) - ONE;
            end
            if (hs && state == DATA_HI) hi_byte <= in_data;
            if (hs && state == DATA_LO && !last_word) k <= k + ONE;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over data bytes only; length bytes are excluded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum <= 8'd0;
        end else if (hs && (state == DATA_HI || state == DATA_LO)) begin
            csum <= csum ^ in_data;
        end
    end
`endif

    // Memory write port: one-cycle strobe after each completed word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 16'd0;
        end else begin
            imem_we <= hs && (state == DATA_LO);
            if (hs && state == DATA_LO) begin
                imem_addr  <= k[ADDR_W-1:0];
                imem_wdata <= {hi_byte, in_data};
            end
        end
    end

    // Status outputs: ready/done/error follow the next state so they switch on the
    // entry edge; cpu_rst follows the current state, one cycle after DONE entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_rst  <= 1'b0;
        end else begin
            in_ready <= (state_nxt != DONE) && (state_nxt != ERR);
            done     <= (state_nxt == DONE);
            error    <= (state_nxt == ERR);
            cpu_rst  <= (state == DONE);
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the CPU top and its instruction memory. It takes a byte stream (length header plus big-endian 16-bit instruction words) over a valid/ready interface and writes each word into the instruction ROM at consecutive addresses. It holds the CPU in reset until the image is fully written, then releases it. This replaces testbench-side ROM preloading in hardware builds.

## Interface
- `IMEM_DEPTH`, 512: instruction memory depth in words; maximum accepted word count.
- `ADDR_W`, 9: instruction memory address width; must satisfy 2^ADDR_W >= IMEM_DEPTH.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `in_data` input 8: stream byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader accepts a byte. A byte transfers on a rising edge where `in_valid & in_ready`.
- `imem_we` output 1: one-cycle write strobe to the instruction memory.
- `imem_addr` output ADDR_W: write address.
- `imem_wdata` output 16: write data.
- `cpu_rst` output 1: active-low reset to the CPU top. It is held low until the load completes.
- `done` output 1: sticky; the image loaded successfully.
- `error` output 1: sticky; the image was rejected.

## Operation
- States: `LEN_HI`, `LEN_LO`, `DATA_HI`, `DATA_LO`, `CHK` (only when the macro is defined), `DONE`, `ERR`.
- After reset the state is `LEN_HI`. Each state consumes exactly one accepted byte.
- `LEN_HI`/`LEN_LO` capture the word count N, big-endian. On acceptance of the `LEN_LO` byte:
  - N==0 or N>IMEM_DEPTH → `ERR`.
  - Otherwise → `DATA_HI`, with word index k=0.
- `DATA_HI` latches the high byte. `DATA_LO` completes word k:
  - Registers `imem_wdata={hi,lo}` and `imem_addr=k`, and sets `imem_we=1` for the next cycle only.
  - If k==N-1 → `CHK` (macro defined) or `DONE`; else k++ and → `DATA_HI`.
- `DONE` and `ERR` are terminal until `rst`. They accept no bytes (`in_ready=0`).
- `done`/`error` are registered decodes of the `DONE`/`ERR` states.
- `cpu_rst` goes to 1 on the first edge where the state is already `DONE`. It never rises in `ERR`.
- The word counter is ADDR_W+1 bits wide, so N==IMEM_DEPTH is reachable without wrap. Addresses never exceed N-1.
- Bytes are never dropped or duplicated. The FSM advances only on a handshake; idle cycles (`in_valid=0`) hold all state.

## Timing
- Reset values:
  - `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_rst`=0, `done`=0, `error`=0.
  - State=`LEN_HI`, counters=0.
- `in_ready` is registered. It becomes 1 on the first rising edge after `rst` deasserts.
- `in_ready` drops to 0 on the same edge the FSM enters `DONE`/`ERR`.
- Write latency: `imem_we` is asserted in the cycle immediately after the `DATA_LO` handshake edge. It is high for exactly one cycle per word.
- Release timing, with the last handshake at edge E:
  - `DONE` is entered at E; `done`=1 and `imem_we`=1 in cycle E..E+1.
  - `cpu_rst` rises at E+1, so the last write has been committed before the CPU leaves reset.
- Throughput: one byte per cycle with `in_valid` held high. Minimum load time is 2+2N (+1 with checksum) cycles.
- Reset mid-load (`rst` low at any time) immediately forces all reset values, including `cpu_rst`=0. The next load restarts at `LEN_HI` with address 0.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN`
  - Defined: an 8-bit running XOR of all data bytes (not length bytes) is kept. After the last word the FSM enters `CHK` and accepts one more byte. Equal to the XOR → `DONE`; unequal → `ERR`, and `cpu_rst` stays 0 even though the words were written.
  - Undefined: there is no `CHK` state and no checksum byte. The last `DATA_LO` handshake goes directly to `DONE`.

## Test plan
- Stream 00 03 12 34 AB CD 00 01, `in_valid` always high (macro off):
  - 3 single-cycle `imem_we` pulses: addr 0/0x1234, 1/0xABCD, 2/0x0001.
  - `done`=1 and `in_ready`=0 after the last byte; `cpu_rst` rises exactly one cycle after the last `imem_we`.
- Stream 00 00 → `error`=1, `in_ready`=0, no `imem_we`, `cpu_rst` stays 0. Further bytes are ignored.
- Stream 02 01 (N=513, IMEM_DEPTH=512) → `error`=1, no writes.
- The same 3-word stream as the first case, with `in_valid` toggled every other cycle and random 0–3 cycle gaps → identical write sequence, no duplicate or missing words.
- 2-word load, `rst` pulsed low after the first word is written → all outputs return to their reset values. A new stream 00 01 55 AA then writes 0x55AA at addr 0, and `done`=1.
- Macro defined, stream 00 01 12 34 26 (0x12^0x34=0x26) → `done`=1, `cpu_rst`=1. The same stream with checksum 27 → `error`=1, `cpu_rst`=0, and the single write at addr 0 still occurred.
